// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-type codes, FSM
// state encoding and the address-lane legality check.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LD_RD = 2'b01,
    RESP  = 2'b10
  } state_t;

  function automatic logic ctrl_illegal(input logic [2:0] ctrl);
    return ctrl > DM_BYTE_U;
  endfunction

  // Words need lane 0, halves need an even lane; bytes are always aligned.
  function automatic logic lane_err(input logic [2:0] ctrl, input logic [1:0] lane);
    logic e;
    e = 1'b0;
    case (ctrl)
      DM_WORD:            e = (lane != 2'd0);
      DM_HALF, DM_HALF_U: e = lane[0];
      default:            e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dm_align.sv
// Byte-lane alignment. STORE=1: replicate store data across lanes and produce
// byte enables. STORE=0: select byte/half from a read word and extend it.
module dm_align
  import dm_pkg::*;
#(
  parameter bit STORE = 1'b1
) (
  input  logic [2:0]  ctrl,
  input  logic [1:0]  lane,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [3:0]  be
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    dout  = '0;
    be    = '0;
    sel_b = din[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? din[31:16] : din[15:0];
    if (STORE) begin
      case (ctrl)
        DM_WORD: begin
          dout = din;
          be   = 4'b1111;
        end
        DM_HALF, DM_HALF_U: begin
          dout = {2{din[15:0]}};
          be   = lane[1] ? 4'b1100 : 4'b0011;
        end
        DM_BYTE, DM_BYTE_U: begin
          dout = {4{din[7:0]}};
          be   = 4'b0001 << lane;
        end
        default: ;
      endcase
    end else begin
      case (ctrl)
        DM_WORD:   dout = din;
        DM_HALF:   dout = {{16{sel_h[15]}}, sel_h};
        DM_HALF_U: dout = {16'h0000, sel_h};
        DM_BYTE:   dout = {{24{sel_b[7]}}, sel_b};
        DM_BYTE_U: dout = {24'h000000, sel_b};
        default:   dout = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the CPU load/store port: one request at a time,
// store latency 1, load latency 2, single-cycle ready pulse with err on rejects.
module dmem_responder
  import dm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [2:0]            dm_ctrl,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic                  req_err;
  logic                  wr_en;
  logic [31:0]           st_word;
  logic [3:0]            st_be;
  logic [31:0]           rd_word;
  logic [1:0]            ld_lane;
  logic [2:0]            ld_ctrl;
  logic [31:0]           ld_fmt;
  logic [3:0]            ld_be_unused;

  assign off  = addr - BASE_ADDR;
  assign widx = off[ADDR_WIDTH+1:2];
  assign lane = off[1:0];

  assign req_err = ctrl_illegal(dm_ctrl) || lane_err(dm_ctrl, lane) ||
                   (addr < BASE_ADDR) || ((off >> (ADDR_WIDTH + 2)) != 32'd0);

  // rst is asynchronous, so a write must never slip through while it is held.
  assign wr_en = !rst && (state == IDLE) && req && we && !req_err;

  dm_align #(.STORE(1'b1)) u_st_align (
    .ctrl (dm_ctrl),
    .lane (lane),
    .din  (wdata),
    .dout (st_word),
    .be   (st_be)
  );

  dm_align #(.STORE(1'b0)) u_ld_align (
    .ctrl (ld_ctrl),
    .lane (ld_lane),
    .din  (rd_word),
    .dout (ld_fmt),
    .be   (ld_be_unused)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[widx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      rd_word <= '0;
      ld_lane <= '0;
      ld_ctrl <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (req_err) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else if (we) begin
              state <= RESP;
              ready <= 1'b1;
            end else begin
              rd_word <= mem[widx];
              ld_lane <= lane;
              ld_ctrl <= dm_ctrl;
              state   <= LD_RD;
            end
          end
        end
        LD_RD: begin
          rdata <= ld_fmt;
          ready <= 1'b1;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus a randomized
// run checked against a byte-level reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_data;

  int passed = 0;
  int total  = 0;

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .dm_ctrl  (dm_ctrl),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] c, input int ln);
    logic [31:0] b, h;
    b = (w >> (8 * ln)) & 32'hFF;
    h = (w >> (16 * (ln / 2))) & 32'hFFFF;
    case (c)
      3'd0:    return w;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [2:0] c, input int ln);
    logic [31:0] r;
    int n;
    if (c == 3'd0) return d;
    r = old;
    n = (c <= 3'd2) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      r = r & ~(32'hFF << (8 * (ln + k)));
      r = r | (((d >> (8 * k)) & 32'hFF) << (8 * (ln + k)));
    end
    return r;
  endfunction

  // Presents one request, scrambles inputs after acceptance, waits (bounded)
  // for ready and reports latency, outputs, and ready one cycle later.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                        output int lat, output logic [31:0] rd, output logic e, output logic rdy_after);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; dm_ctrl = c;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; dm_ctrl = 3'($urandom_range(0, 7));
    lat = 1;
    while (!ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) lat = 99;
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; dm_ctrl = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic e, ra;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, lat, rd, e, ra);
    total++; if (lat !== 1) $display("FAIL st_word_lat: got %0d want 1", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL st_word_err: got %b want 0", e); else passed++;
    total++; if (ra !== 1'b0) $display("FAIL st_word_pulse: ready still %b want 0", ra); else passed++;
    do_req(1'b0, 32'h10, 32'h0, 3'd0, lat, rd, e, ra);
    total++; if (lat !== 2) $display("FAIL ld_word_lat: got %0d want 2", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_word_data: got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic e, ra;
    do_req(1'b1, 32'h10, 32'h11223344, 3'd0, lat, rd, e, ra);
    do_req(1'b1, 32'h12, 32'h000000F0, 3'd3, lat, rd, e, ra);
    total++; if (lat !== 1 || e !== 1'b0) $display("FAIL st_byte: got lat %0d err %b want 1/0", lat, e); else passed++;
    dbg_addr = 10'd4; #1;
    total++; if (dbg_data !== 32'h11F03344) $display("FAIL st_byte_mem: got %h want 11f03344", dbg_data); else passed++;
    do_req(1'b0, 32'h12, 32'h0, 3'd3, lat, rd, e, ra);
    total++; if (rd !== 32'hFFFFFFF0) $display("FAIL ld_byte: got %h want fffffff0", rd); else passed++;
    do_req(1'b0, 32'h12, 32'h0, 3'd4, lat, rd, e, ra);
    total++; if (rd !== 32'h000000F0) $display("FAIL ld_byte_u: got %h want 000000f0", rd); else passed++;
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic e, ra;
    do_req(1'b1, 32'h0, 32'h80017FFF, 3'd0, lat, rd, e, ra);
    do_req(1'b0, 32'h2, 32'h0, 3'd1, lat, rd, e, ra);
    total++; if (rd !== 32'hFFFF8001) $display("FAIL ld_half_hi: got %h want ffff8001", rd); else passed++;
    do_req(1'b0, 32'h2, 32'h0, 3'd2, lat, rd, e, ra);
    total++; if (rd !== 32'h00008001) $display("FAIL ld_half_u: got %h want 00008001", rd); else passed++;
    do_req(1'b0, 32'h0, 32'h0, 3'd1, lat, rd, e, ra);
    total++; if (rd !== 32'h00007FFF) $display("FAIL ld_half_lo: got %h want 00007fff", rd); else passed++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e, ra;
    do_req(1'b1, 32'h11, 32'hAAAAAAAA, 3'd0, lat, rd, e, ra);
    total++; if (lat !== 1 || e !== 1'b1) $display("FAIL err_mis_word: got lat %0d err %b want 1/1", lat, e); else passed++;
    dbg_addr = 10'd4; #1;
    total++; if (dbg_data !== 32'h11F03344) $display("FAIL err_mem_kept: got %h want 11f03344", dbg_data); else passed++;
    do_req(1'b0, 32'h3, 32'h0, 3'd1, lat, rd, e, ra);
    total++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL err_mis_half: got err %b rdata %h want 1/0", e, rd); else passed++;
    do_req(1'b0, 32'h4, 32'h0, 3'b110, lat, rd, e, ra);
    total++; if (e !== 1'b1) $display("FAIL err_illegal: got err %b want 1", e); else passed++;
    do_req(1'b1, 32'h1000, 32'h12345678, 3'd0, lat, rd, e, ra);
    total++; if (e !== 1'b1 || ra !== 1'b0) $display("FAIL err_range: got err %b ready_after %b want 1/0", e, ra); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    @(negedge clk);
    req = 1'b1; we = 1'b1; dm_ctrl = 3'd0; addr = 32'h0; wdata = 32'hA5A5_0001;
    @(posedge clk); #1; seq[0] = ready;
    addr = 32'h4; wdata = 32'h5A5A_0002;
    @(posedge clk); #1; seq[1] = ready;
    @(posedge clk); #1; seq[2] = ready;
    req = 1'b0;
    @(posedge clk); #1; seq[3] = ready;
    total++; if (seq !== 4'b0101) $display("FAIL b2b_ready_seq: got %b want 0101 (t3..t0)", seq); else passed++;
    dbg_addr = 10'd0; #1;
    total++; if (dbg_data !== 32'hA5A50001) $display("FAIL b2b_word0: got %h want a5a50001", dbg_data); else passed++;
    dbg_addr = 10'd1; #1;
    total++; if (dbg_data !== 32'h5A5A0002) $display("FAIL b2b_word1: got %h want 5a5a0002", dbg_data); else passed++;
  endtask

  task automatic test_reset_mid_load();
    int lat; logic [31:0] rd; logic e, ra; logic seen;
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 3'd0, lat, rd, e, ra);
    do_req(1'b0, 32'h20, 32'h0, 3'd0, lat, rd, e, ra);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h20; dm_ctrl = 3'd0;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1; #1;
    total++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0)
      $display("FAIL rst_mid_outputs: got ready %b err %b rdata %h want 0/0/0", ready, err, rdata); else passed++;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen = seen | ready; end
    @(negedge clk); rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen = seen | ready; end
    total++; if (seen !== 1'b0) $display("FAIL rst_mid_no_ready: got %b want 0", seen); else passed++;
    do_req(1'b0, 32'h20, 32'h0, 3'd0, lat, rd, e, ra);
    total++; if (lat !== 2 || rd !== 32'hCAFEF00D) $display("FAIL rst_mid_reload: got lat %0d rdata %h want 2/cafef00d", lat, rd); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] mdl [16];
    logic [31:0] last_rd, a, d, rd, exp_rd;
    logic [2:0]  c;
    logic        w, e, ra, exp_err;
    int          lat, exp_lat, ln, wi, pick;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_req(1'b1, 32'(i * 4), d, 3'd0, lat, rd, e, ra);
      mdl[i] = d;
    end
    last_rd = rdata;
    for (int n = 0; n < 120; n++) begin
      w    = 1'($urandom_range(0, 1));
      c    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (pick == 1) a = 32'hFFFF_FF00 | $urandom_range(0, 255);
      else                a = $urandom_range(0, 63);
      d  = $urandom;
      ln = int'(a[1:0]);
      wi = int'(a[5:2]);
      exp_err = (c > 3'd4) || (c == 3'd0 && ln != 0) || ((c == 3'd1 || c == 3'd2) && (ln % 2) == 1) ||
                (a >= 32'd4096);
      do_req(w, a, d, c, lat, rd, e, ra);
      if (exp_err) begin
        exp_lat = 1; exp_rd = 32'd0;
      end else if (w) begin
        exp_lat = 1; exp_rd = last_rd;
        mdl[wi] = ref_store(mdl[wi], d, c, ln);
      end else begin
        exp_lat = 2; exp_rd = ref_load(mdl[wi], c, ln);
      end
      last_rd = exp_rd;
      total++; if (lat !== exp_lat || e !== exp_err || rd !== exp_rd || ra !== 1'b0)
        $display("FAIL rand_%0d: we %b a %h c %0d got lat %0d err %b rdata %h rdy_after %b want %0d/%b/%h/0",
                 n, w, a, c, lat, e, rd, ra, exp_lat, exp_err, exp_rd);
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 10'(i); #1;
      total++; if (dbg_data !== mdl[i]) $display("FAIL rand_mem_%0d: got %h want %h", i, dbg_data, mdl[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
